// File: rtl/temporizador_pkg.sv
// Shared definitions for the temporizador three-channel duty timer:
// default counter width, FSM state type and flag bit positions.
package temporizador_pkg;

    localparam int CNT_W_DEFAULT = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FLAG_R = 0;
    localparam int FLAG_G = 1;
    localparam int FLAG_B = 2;

endpackage : temporizador_pkg

// File: rtl/temporizador_canal.sv
// One timer channel: holds the count captured at run start and drives
// one registered flag that stays high while the run position is below
// that count.
module temporizador_canal
    import temporizador_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_ciclos,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_flag
);

    logic [CNT_W-1:0] r_lat;
    logic             r_flag;
    logic [CNT_W:0]   w_cnt_inc;

    // Next run position, one bit wider so the compare never wraps.
    assign w_cnt_inc = {1'b0, i_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Capture the count on load; update the flag from the next run position.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat  <= '0;
            r_flag <= 1'b0;
        end else if (i_load) begin
            r_lat  <= i_ciclos;
            r_flag <= (i_ciclos != '0);
        end else if (i_clear) begin
            r_flag <= 1'b0;
        end else if (i_step) begin
            r_flag <= (w_cnt_inc < {1'b0, r_lat});
        end
    end

    assign o_flag = r_flag;

endmodule : temporizador_canal

// File: rtl/temporizador.sv
// Three-channel one-shot duty timer for the RGB LED path.
// A rising edge on enter captures the R/G/B counts and starts a fixed
// 2**CNT_W cycle run; each flag is high for its captured number of cycles.
// Optional build macro TEMPORIZADOR_RETRIGGER_EN: a rising edge during a
// run restarts it with freshly captured counts.
module temporizador
    import temporizador_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic [CNT_W-1:0] ciclos_R,
    input  logic [CNT_W-1:0] ciclos_G,
    input  logic [CNT_W-1:0] ciclos_B,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_enter_d;
    logic             w_rise;
    logic             w_load;
    logic             w_clear;
    logic             w_step;

    assign w_rise = enter & ~r_enter_d;

    // State, run counter, busy and edge-detect history registers.
    // enter_d resets high so a level already high at release is not a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_enter_d <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_enter_d <= enter;
        end
    end

    // Next-state, counter and channel strobes.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == CNT_MAX) begin
                    // Run ends; a rise on this same edge is deliberately dropped.
                    w_clear     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
`ifdef TEMPORIZADOR_RETRIGGER_EN
                end else if (w_rise) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
`endif
                end else begin
                    w_step      = 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_clear     = 1'b1;
            end
        endcase
    end

    temporizador_canal #(.CNT_W(CNT_W)) u_canal_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_ciclos (ciclos_R),
        .i_cnt    (r_cnt),
        .o_flag   (flags[FLAG_R])
    );

    temporizador_canal #(.CNT_W(CNT_W)) u_canal_g (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_ciclos (ciclos_G),
        .i_cnt    (r_cnt),
        .o_flag   (flags[FLAG_G])
    );

    temporizador_canal #(.CNT_W(CNT_W)) u_canal_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_step   (w_step),
        .i_ciclos (ciclos_B),
        .i_cnt    (r_cnt),
        .o_flag   (flags[FLAG_B])
    );

    assign busy = r_busy;

endmodule : temporizador

// File: tb/tb_temporizador.sv
// Self-checking bench for temporizador. A reference model predicts the
// {busy, flags} value for every clock cycle and queues it; a monitor on
// the falling edge pops and compares against the DUT.
module tb_temporizador;

    localparam int CNT_W   = 5;
    localparam int RUN_LEN = 1 << CNT_W;

    logic             clk;
    logic             rst_n;
    logic             enter;
    logic [CNT_W-1:0] ciclos_R;
    logic [CNT_W-1:0] ciclos_G;
    logic [CNT_W-1:0] ciclos_B;
    logic [2:0]       flags;
    logic             busy;

    int vectors    = 0;
    int miscompares = 0;

    temporizador #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enter    (enter),
        .ciclos_R (ciclos_R),
        .ciclos_G (ciclos_G),
        .ciclos_B (ciclos_B),
        .flags    (flags),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got busy=%b flags=%b want busy=%b flags=%b",
                     name, $time, got[3], got[2:0], want[3], want[2:0]);
        end
    endtask

    // ---------------- reference model ----------------
    // pos = cycles elapsed since the run started, -1 when no run.
    logic [3:0] exp_q[$];
    int         m_pos   = -1;
    logic       m_prev  = 1'b1;
    int         m_lat[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  = -1;
            m_prev = 1'b1;
            exp_q.delete();
        end else begin
            logic       rise;
            logic [3:0] e;
            rise   = enter && !m_prev;
            m_prev = enter;
            if (m_pos >= 0) begin
                if (m_pos == RUN_LEN - 1) m_pos = -1;
`ifdef TEMPORIZADOR_RETRIGGER_EN
                else if (rise) begin
                    m_pos = 0;
                    m_lat[0] = int'(ciclos_R);
                    m_lat[1] = int'(ciclos_G);
                    m_lat[2] = int'(ciclos_B);
                end
`endif
                else m_pos++;
            end else if (rise) begin
                m_pos = 0;
                m_lat[0] = int'(ciclos_R);
                m_lat[1] = int'(ciclos_G);
                m_lat[2] = int'(ciclos_B);
            end
            e = 4'b0000;
            if (m_pos >= 0) begin
                e[3] = 1'b1;
                for (int i = 0; i < 3; i++) e[i] = (m_pos < m_lat[i]);
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [3:0] want;
        want = 4'b0000;
        if (rst_n && exp_q.size() > 0) want = exp_q.pop_front();
        check("cycle", {busy, flags}, want);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_counts(input int r, input int g, input int b);
        ciclos_R = CNT_W'(r);
        ciclos_G = CNT_W'(g);
        ciclos_B = CNT_W'(b);
    endtask

    initial begin
        rst_n = 1'b0;
        enter = 1'b0;
        set_counts(0, 0, 0);
        #2;
        check("reset_state", {busy, flags}, 4'b0000);
        cyc(3);
        rst_n = 1'b1;
        cyc(3);

        // Staggered counts, enter held high for 10 cycles: one run only.
        set_counts(5, 10, 15);
        enter = 1'b1;
        cyc(10);
        enter = 1'b0;
        cyc(40);

        // Boundary counts 0, 31, 1 with a single-cycle pulse.
        set_counts(0, 31, 1);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        cyc(40);

        // Inputs changed during the run must not matter.
        set_counts(4, 4, 4);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        cyc(2);
        set_counts(20, 20, 20);
        cyc(40);

        // Second pulse at cycle 10 of a run.
        set_counts(7, 12, 25);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        cyc(9);
        set_counts(3, 30, 9);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        cyc(50);

        // Asynchronous reset mid-run at cycle 3.
        set_counts(10, 10, 10);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy, flags}, 4'b0000);
        cyc(2);
        rst_n = 1'b1;
        cyc(40);

        // enter held high through reset release: no run until a new edge.
        enter = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(40);
        enter = 1'b0;
        cyc(2);
        set_counts(31, 16, 2);
        enter = 1'b1;
        cyc(3);
        enter = 1'b0;
        cyc(40);

        // Random enter activity and counts, including rises at run end.
        for (int k = 0; k < 1500; k++) begin
            set_counts(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)));
            enter = ($urandom_range(0, 7) == 0) ? ~enter : enter;
            cyc(1);
        end
        enter = 1'b0;
        cyc(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL timeout t=%0t got no_finish want finish", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_temporizador

// File: doc/temporizador.md
Name: temporizador

Overview:
- Three-channel one-shot duty timer for the RGB LED path.
- A rising edge on `enter` latches three 5-bit cycle counts (R, G, B) and starts a fixed 32-cycle run.
- Each flag is high from the start of the run for exactly its latched number of cycles.
- Sits between the colour-selection logic and the RGB LED drivers.

Parameters:
- CNT_W, 5, width of the cycle-count inputs and of the internal run counter; run length is 2**CNT_W cycles.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- enter  input  1  start request; level signal, edge-detected internally.
- ciclos_R  input  CNT_W  high-time in cycles for flags[0].
- ciclos_G  input  CNT_W  high-time in cycles for flags[1].
- ciclos_B  input  CNT_W  high-time in cycles for flags[2].
- flags  output  3  registered channel flags {B,G,R}.
- busy  output  1  registered; high while a run is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, latched counts=0, flags=3'b000, busy=0, enter_d=1.
  - enter_d=1 means a level already high at reset release does not start a run; a genuine 0->1 transition is required.
- Edge detect: rise = enter & ~enter_d; enter_d <= enter every cycle.
- States: IDLE, RUN.
- IDLE, rise=1, on this clock edge:
  - lat_R/G/B <= ciclos_R/G/B; cnt <= 0; state <= RUN; busy <= 1.
  - flags[i] <= (ciclos_i != 0).
- IDLE, rise=0: outputs hold 0.
- RUN, each edge:
  - if cnt == 2**CNT_W-1: state <= IDLE, cnt <= 0, flags <= 0, busy <= 0.
  - else: cnt <= cnt+1; flags[i] <= ((cnt+1) < lat_i), unsigned CNT_W+1-bit compare.
- Result: flag i is high for exactly lat_i cycles, starting with the first RUN cycle.
  - ciclos=0 -> flag never asserts.
  - ciclos=31 -> flag high 31 of 32 cycles.
- Run length is always 32 cycles (busy high 32 cycles), independent of the counts.
- ciclos inputs are sampled only at the start edge; changes during RUN have no effect.
- enter held high for many cycles produces one run only.
- rise during RUN: ignored (see Optional Feature).
- Rise on the same edge as RUN->IDLE: ignored; a new edge is needed afterwards.
- Reset mid-run: immediate abort to reset values.

Optional Feature:
- Macro: TEMPORIZADOR_RETRIGGER_EN.
- Defined: a rise during RUN reloads lat_* from the current inputs, sets cnt <= 0 and recomputes flags as for a start; busy stays 1.
- Undefined: a rise during RUN is ignored; the current run completes unchanged.

Decomposition:
- Shared package temporizador_pkg:
  - CNT_W default;
  - state enum typedef {IDLE, RUN};
  - flag index constants FLAG_R=0, FLAG_G=1, FLAG_B=2.
- Sub-module temporizador_canal, instantiated three times:
  - holds one latched count;
  - produces one registered flag from the shared cnt, load and clear strobes.
- The top module keeps the edge detector, FSM and counter.

Test Plan:
- R=5, G=10, B=15; enter 0->1 held 10 cycles -> flags=111 for 5 cycles, 110 for 5, 100 for 5, then 000; busy high exactly 32 cycles; no second run.
- R=0, G=31, B=1; single pulse -> flags[0] never high; flags[2] high 1 cycle; flags[1] high 31 cycles; busy 32.
- Start with R=G=B=4; change inputs to 20 at cycle 2 of the run -> all flags still drop after 4 cycles.
- Second enter pulse at cycle 10 of a run:
  - macro off -> run ends at cycle 32 from the first edge;
  - macro on -> counts restart, busy ends 32 cycles after the second edge.
- rst_n pulsed low mid-run at cycle 3 with R=10 -> flags=000 and busy=0 asynchronously; no resumption after release.
- enter held high through reset release -> no run until enter goes low then high.
